// File: rtl/pos_mask_pkg.sv
// ============================================================================
// pos_mask_pkg : shared defaults and FSM state encoding for pos_mask_builder
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package pos_mask_pkg;

  localparam int DEF_W  = 8;
  localparam int DEF_PW = $clog2(DEF_W);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pos_onehot_dec.sv
// ============================================================================
// pos_onehot_dec : PW-bit position to W-bit one-hot decoder; positions >= W
//                  decode to all zeros
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module pos_onehot_dec
  import pos_mask_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int PW = $clog2(W)
) (
  input  logic [PW-1:0] pos,
  output logic [W-1:0]  onehot
);

  // Comparing every bit against its own index naturally yields zero for
  // out-of-range positions when W is not a power of two.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign onehot[i] = (pos == PW'(i));
  end

endmodule

`default_nettype wire

// File: rtl/pos_mask_builder.sv
// ============================================================================
// pos_mask_builder : ORs a stream of bit positions into a mask and emits it
//                    on the last beat through a registered valid/ready port.
// Optional macro POS_MASK_DUP_DETECT_EN enables the repeated-position flag.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module pos_mask_builder
  import pos_mask_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int PW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_pos,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_mask,
  output logic          out_dup
);

  state_e       state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] out_mask_q, out_mask_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] w_onehot;
  logic         w_accept;

  pos_onehot_dec #(
    .W  (W),
    .PW (PW)
  ) u_dec (
    .pos    (in_pos),
    .onehot (w_onehot)
  );

  // Ready depends only on state and out_ready, never on in_valid.
  assign in_ready = (state_q == ST_ACCUM) || out_ready;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_mask_d  = out_mask_q;
    out_valid_d = out_valid_q;

    if ((state_q == ST_HOLD) && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ST_ACCUM;
    end

    // acc is always zero in HOLD, so a beat taken during the handshake
    // cycle starts a fresh frame.
    if (w_accept) begin
      if (in_last) begin
        out_mask_d  = acc_q | w_onehot;
        out_valid_d = 1'b1;
        acc_d       = '0;
        state_d     = ST_HOLD;
      end else begin
        acc_d = acc_q | w_onehot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      out_mask_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_mask_q  <= out_mask_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_mask  = out_mask_q;
  assign out_valid = out_valid_q;

`ifdef POS_MASK_DUP_DETECT_EN
  logic dup_q, dup_d;
  logic out_dup_q, out_dup_d;
  logic w_hit;

  assign w_hit = |(acc_q & w_onehot);

  always_comb begin
    dup_d     = dup_q;
    out_dup_d = out_dup_q;
    if (w_accept) begin
      if (in_last) begin
        out_dup_d = dup_q | w_hit;
        dup_d     = 1'b0;
      end else begin
        dup_d = dup_q | w_hit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dup_q     <= 1'b0;
      out_dup_q <= 1'b0;
    end else begin
      dup_q     <= dup_d;
      out_dup_q <= out_dup_d;
    end
  end

  assign out_dup = out_dup_q;
`else
  assign out_dup = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pos_mask_builder.sv
// ============================================================================
// tb_pos_mask_builder : directed self-checking bench for pos_mask_builder
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_pos_mask_builder;

  localparam int W  = 8;
  localparam int PW = 3;

`ifdef POS_MASK_DUP_DETECT_EN
  localparam logic c_dup_exp = 1'b1;
`else
  localparam logic c_dup_exp = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_pos;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_mask;
  logic          out_dup;

  int n_checks = 0;
  int n_fail   = 0;

  pos_mask_builder #(
    .W  (W),
    .PW (PW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pos    (in_pos),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_dup   (out_dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [PW-1:0] p, input logic l);
    in_valid = v;
    in_pos   = p;
    in_last  = l;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_out_mask",  32'(out_mask),  32'h00);
    check_eq("rst_out_dup",   32'(out_dup),   32'h0);
    check_eq("rst_in_ready",  32'(in_ready),  32'h1);
    rst_n = 1'b1;
    tick();

    // Frame 0,3,7 -> 0x89, valid for exactly one cycle
    out_ready = 1'b1;
    drive(1'b1, 3'd0, 1'b0); tick();
    check_eq("f1_beat0_valid", 32'(out_valid), 32'h0);
    drive(1'b1, 3'd3, 1'b0); tick();
    check_eq("f1_beat1_valid", 32'(out_valid), 32'h0);
    drive(1'b1, 3'd7, 1'b1); tick();
    check_eq("f1_valid", 32'(out_valid), 32'h1);
    check_eq("f1_mask",  32'(out_mask),  32'h89);
    check_eq("f1_dup",   32'(out_dup),   32'h0);
    drive(1'b0, 3'd0, 1'b0); tick();
    check_eq("f1_valid_drop", 32'(out_valid), 32'h0);

    // Back-to-back single-beat frames
    drive(1'b1, 3'd5, 1'b1); tick();
    check_eq("b2b_a_valid", 32'(out_valid), 32'h1);
    check_eq("b2b_a_mask",  32'(out_mask),  32'h20);
    drive(1'b1, 3'd1, 1'b1);
    check_eq("b2b_in_ready", 32'(in_ready), 32'h1);
    tick();
    check_eq("b2b_b_valid", 32'(out_valid), 32'h1);
    check_eq("b2b_b_mask",  32'(out_mask),  32'h02);
    drive(1'b0, 3'd0, 1'b0); tick();
    check_eq("b2b_valid_drop", 32'(out_valid), 32'h0);

    // Backpressure hold
    out_ready = 1'b0;
    drive(1'b1, 3'd2, 1'b1); tick();
    check_eq("bp_valid", 32'(out_valid), 32'h1);
    check_eq("bp_mask",  32'(out_mask),  32'h04);
    drive(1'b1, 3'd6, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_in_ready", 32'(in_ready), 32'h0);
      tick();
      check_eq("bp_hold_valid", 32'(out_valid), 32'h1);
      check_eq("bp_hold_mask",  32'(out_mask),  32'h04);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(in_ready), 32'h1);
    tick();
    check_eq("bp_next_valid", 32'(out_valid), 32'h1);
    check_eq("bp_next_mask",  32'(out_mask),  32'h40);
    drive(1'b0, 3'd0, 1'b0); tick();
    check_eq("bp_valid_drop", 32'(out_valid), 32'h0);

    // Repeated position
    drive(1'b1, 3'd4, 1'b0); tick();
    drive(1'b1, 3'd4, 1'b0); tick();
    drive(1'b1, 3'd6, 1'b1); tick();
    check_eq("dup_valid", 32'(out_valid), 32'h1);
    check_eq("dup_mask",  32'(out_mask),  32'h50);
    check_eq("dup_flag",  32'(out_dup),   32'(c_dup_exp));
    drive(1'b1, 3'd1, 1'b1); tick();
    check_eq("dup_clear_mask", 32'(out_mask), 32'h02);
    check_eq("dup_clear_flag", 32'(out_dup),  32'h0);
    drive(1'b0, 3'd0, 1'b0); tick();

    // Reset mid-frame discards the partial accumulator
    drive(1'b1, 3'd1, 1'b0); tick();
    drive(1'b1, 3'd2, 1'b0); tick();
    drive(1'b0, 3'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'h0);
    check_eq("mid_rst_mask",  32'(out_mask),  32'h00);
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b1, 3'd0, 1'b1); tick();
    check_eq("post_rst_valid", 32'(out_valid), 32'h1);
    check_eq("post_rst_mask",  32'(out_mask),  32'h01);
    drive(1'b0, 3'd0, 1'b0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
